// File: rtl/kt_pkg.sv
// Shared types and constants for the KnightsTour command arbitration path.
package kt_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    EXEC  = 3'd2,
    RESP  = 3'd3,
    ABORT = 3'd4
  } arb_state_t;

  typedef enum logic {
    OWN_RMT  = 1'b0,
    OWN_TOUR = 1'b1
  } owner_t;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_NAK = 8'hEE;

endpackage

// File: rtl/cmd_wdog.sv
// Watchdog counter: cleared on grant, counts while enabled, and flags the
// final allowed cycle (count == TIMEOUT-1).
module cmd_wdog #(
  parameter int TIMEOUT = 100_000_000,
  parameter int TMR_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] count;

  // Saturates at LAST so a stalled enable can never wrap and re-arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && (count != LAST))
      count <= count + TMR_W'(1);
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/cmd_arb.sv
// Arbitrates the single cmd_proc command port between the remote UART stream
// and the tour sequencer, with round-robin tie-break and a completion watchdog.
module cmd_arb
  import kt_pkg::*;
#(
  parameter int TIMEOUT = 100_000_000,
  parameter int TMR_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] rmt_cmd,
  input  logic        rmt_cmd_rdy,
  output logic        rmt_clr_cmd_rdy,
  input  logic [15:0] tour_cmd,
  input  logic        tour_cmd_rdy,
  output logic        tour_clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic        rmt_send_resp,
  output logic        tour_resp_ack,
  output logic        tour_fault,
  output logic        busy,
  output logic        owner
);

  arb_state_t state, state_nxt;
  owner_t     owner_q;
  logic       grant;
  logic       gnt_tour;
  logic       expired;

  cmd_wdog #(.TIMEOUT(TIMEOUT), .TMR_W(TMR_W)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (grant),
    .en      ((state == ISSUE) || (state == EXEC)),
    .expired (expired)
  );

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    gnt_tour  = 1'b0;
    case (state)
      IDLE: begin
        if (rmt_cmd_rdy || tour_cmd_rdy) begin
          grant     = 1'b1;
          gnt_tour  = tour_cmd_rdy && (!rmt_cmd_rdy || (owner_q == OWN_RMT));
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (send_resp)        state_nxt = RESP;
        else if (expired)     state_nxt = ABORT;
        else if (clr_cmd_rdy) state_nxt = EXEC;
      end
      EXEC: begin
        if (send_resp)    state_nxt = RESP;
        else if (expired) state_nxt = ABORT;
      end
      RESP, ABORT: state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments only; pulses default low each edge and the
  // later conditional assignments override that default.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      owner_q          <= OWN_TOUR;
      cmd              <= 16'h0000;
      cmd_rdy          <= 1'b0;
      resp             <= RESP_ACK;
      rmt_clr_cmd_rdy  <= 1'b0;
      tour_clr_cmd_rdy <= 1'b0;
      rmt_send_resp    <= 1'b0;
      tour_resp_ack    <= 1'b0;
      tour_fault       <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= state_nxt;
      busy             <= (state_nxt != IDLE);
      rmt_clr_cmd_rdy  <= 1'b0;
      tour_clr_cmd_rdy <= 1'b0;
      rmt_send_resp    <= 1'b0;
      tour_resp_ack    <= 1'b0;
      tour_fault       <= 1'b0;

      if (grant) begin
        cmd              <= gnt_tour ? tour_cmd : rmt_cmd;
        owner_q          <= gnt_tour ? OWN_TOUR : OWN_RMT;
        cmd_rdy          <= 1'b1;
        rmt_clr_cmd_rdy  <= !gnt_tour;
        tour_clr_cmd_rdy <= gnt_tour;
      end

      if ((state_nxt == EXEC) || (state_nxt == RESP) || (state_nxt == ABORT))
        cmd_rdy <= 1'b0;

      if (state_nxt == RESP) begin
        if (owner_q == OWN_RMT) begin
          rmt_send_resp <= 1'b1;
          resp          <= RESP_ACK;
        end else begin
          tour_resp_ack <= 1'b1;
        end
      end

      if (state_nxt == ABORT) begin
        if (owner_q == OWN_RMT) begin
          rmt_send_resp <= 1'b1;
          resp          <= RESP_NAK;
        end else begin
          tour_fault <= 1'b1;
        end
      end
    end
  end

  assign owner = owner_q;

endmodule

// File: doc/cmd_arb.md
Name: cmd_arb

Overview:
- Shares the single cmd_proc command port between two requesters:
  - the remote UART command stream (UART_wrapper);
  - the autonomous tour sequencer (TourCmd).
- Grants one command at a time, holds the grant until cmd_proc signals completion or a watchdog expires, then routes the completion response back to the owner.
- Sits inside KnightsTour between UART_wrapper/TourCmd and cmd_proc.

Parameters:
- TIMEOUT, 100_000_000: cycles allowed from grant to completion before the command is aborted (2 s at 50 MHz).
- TMR_W, $clog2(TIMEOUT+1): watchdog counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rmt_cmd  in  16  remote command word.
- rmt_cmd_rdy  in  1  remote command pending; level, held until cleared.
- rmt_clr_cmd_rdy  out  1  one-cycle pulse: remote command consumed.
- tour_cmd  in  16  tour command word.
- tour_cmd_rdy  in  1  tour command pending; level, held until cleared.
- tour_clr_cmd_rdy  out  1  one-cycle pulse: tour command consumed.
- cmd  out  16  registered command presented to cmd_proc.
- cmd_rdy  out  1  command valid to cmd_proc.
- clr_cmd_rdy  in  1  cmd_proc accepted cmd.
- send_resp  in  1  cmd_proc completed command (pulse).
- resp  out  8  response byte to UART_wrapper.
- rmt_send_resp  out  1  one-cycle pulse: transmit resp over UART.
- tour_resp_ack  out  1  one-cycle pulse: tour command completed.
- tour_fault  out  1  one-cycle pulse: tour command timed out.
- busy  out  1  high in every state except IDLE.
- owner  out  1  0 = remote, 1 = tour; current or last grant.

Behaviour:
- Reset, asynchronous:
  - state = IDLE;
  - cmd = 16'h0000, resp = RESP_ACK;
  - all pulse outputs 0, cmd_rdy 0, busy 0;
  - owner = TOUR, so remote wins the first tie;
  - watchdog = 0.
- Reset mid-operation returns to IDLE immediately. No response is issued. A requester's cmd_rdy stays pending and is re-arbitrated after reset.
- States: IDLE, ISSUE, EXEC, RESP, ABORT.
- IDLE, request present at a clock edge:
  - grant goes to the single requester, or on a tie to the requester that is not owner (round-robin);
  - at that edge: cmd loaded with the granted word, owner updated, state -> ISSUE, watchdog cleared;
  - in the next cycle, exactly one cycle: the granted requester's clr pulse and cmd_rdy are both high.
- ISSUE:
  - cmd_rdy held high;
  - on clr_cmd_rdy: cmd_rdy drops next cycle, state -> EXEC;
  - clr_cmd_rdy and send_resp in the same cycle -> RESP directly.
- EXEC: cmd_rdy = 0; wait for send_resp -> RESP.
- Watchdog:
  - increments every cycle in ISSUE and EXEC;
  - at count == TIMEOUT-1 with no send_resp that cycle -> ABORT;
  - send_resp wins over simultaneous expiry.
- RESP, one cycle, then -> IDLE:
  - owner remote: rmt_send_resp = 1, resp = RESP_ACK (8'hA5);
  - owner tour: tour_resp_ack = 1.
- ABORT, one cycle, then -> IDLE:
  - cmd_rdy forced 0;
  - owner remote: rmt_send_resp = 1, resp = RESP_NAK (8'hEE);
  - owner tour: tour_fault = 1.
- After either RESP or ABORT, a pending request is granted on the IDLE edge, so the earliest new grant is 2 cycles after the RESP cycle.
- Requests arriving while busy are neither cleared nor lost. They stay pending and are arbitrated at the next IDLE.
- send_resp or clr_cmd_rdy while in IDLE is ignored.
- All outputs are registered.

Decomposition:
- kt_pkg holds:
  - typedef enum arb_state_t {IDLE, ISSUE, EXEC, RESP, ABORT};
  - typedef enum logic owner_t {OWN_RMT = 0, OWN_TOUR = 1};
  - localparams RESP_ACK = 8'hA5, RESP_NAK = 8'hEE.
- One sub-module, cmd_wdog: a parameterised watchdog counter with inputs clr and en and output expired (high at TIMEOUT-1).

Test Plan:
- Reset with rmt_cmd_rdy = 1, rmt_cmd = 16'h2000 (calibrate) -> no grant during reset. After release: cmd = 16'h2000, cmd_rdy = 1, rmt_clr_cmd_rdy pulsed once. Assert clr_cmd_rdy, then send_resp -> rmt_send_resp pulse with resp = 8'hA5, busy = 0 the following cycle.
- Both requesters pending from reset, rmt_cmd = 16'h4001, tour_cmd = 16'h4002 -> 16'h4001 granted first. After completion, 16'h4002 granted with owner = 1, and tour_resp_ack pulses on its send_resp.
- TIMEOUT = 50, remote command accepted, send_resp never asserted -> ABORT exactly 50 cycles after the grant edge, with rmt_send_resp = 1, resp = 8'hEE, cmd_rdy = 0. Tour owner in the same case -> tour_fault pulse and no rmt_send_resp.
- send_resp coincident with the watchdog's final count -> RESP path taken: resp = 8'hA5, no tour_fault.
- clr_cmd_rdy and send_resp in the same ISSUE cycle -> single RESP pulse, no EXEC state; a second send_resp while IDLE -> no output.
- rst_n low while in EXEC with tour pending -> all outputs return to reset values asynchronously. After release, the pending requests are re-granted, with remote first on a tie.
